// File: rtl/pifo_task_pkg.sv
// Shared definitions for the PIFO task arbiter slice.
// Holds the default geometry of the arbiter, the push/pop opcode encoding,
// the dispatch FSM state type and the packed task word layout
// {op, tree_id, data} that travels through the shared task FIFO.
package pifo_task_pkg;

  localparam int DEF_PTW           = 16;
  localparam int DEF_MTW           = 16;
  localparam int DEF_TREE_NUM      = 4;
  localparam int DEF_TREE_NUM_BITS = $clog2(DEF_TREE_NUM);
  localparam int DEF_TREE_CAP      = 1024;
  localparam int DEF_TW            = DEF_PTW + DEF_MTW + DEF_TREE_NUM_BITS + 1;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } disp_state_t;

  typedef struct packed {
    logic                             op;
    logic [DEF_TREE_NUM_BITS-1:0]     tree_id;
    logic [DEF_PTW+DEF_MTW-1:0]       data;
  } task_t;

endpackage

// File: rtl/pifo_task_arbiter_if.sv
// Bundle of the requester, task FIFO and PIFO-core handshake signals.
//   req_valid/req_op/req_data -> requests from the TREE_NUM trees
//   req_ready                 <- one-hot grant
//   fifo_wr_en/fifo_din       <- task FIFO write side
//   fifo_full/fifo_empty      -> task FIFO status
//   fifo_rd_en / fifo_dout    <- / -> task FIFO read side (1-cycle latency)
//   task_valid/task_word      <- task presented to the PIFO core
//   task_ready                -> core accepts the task
//   drop                      <- accepted request discarded by the guard
// Modport master is the arbiter's view, slave is the surrounding system.
interface pifo_task_arbiter_if #(
  parameter int PTW           = 16,
  parameter int MTW           = 16,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int TW            = PTW + MTW + TREE_NUM_BITS + 1
);

  logic [TREE_NUM-1:0]           req_valid;
  logic [TREE_NUM-1:0]           req_op;
  logic [TREE_NUM*(PTW+MTW)-1:0] req_data;
  logic [TREE_NUM-1:0]           req_ready;
  logic                          fifo_wr_en;
  logic [TW-1:0]                 fifo_din;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_rd_en;
  logic [TW-1:0]                 fifo_dout;
  logic                          task_valid;
  logic [TW-1:0]                 task_word;
  logic                          task_ready;
  logic                          drop;

  modport master (
    input  req_valid, req_op, req_data, fifo_full, fifo_empty, fifo_dout, task_ready,
    output req_ready, fifo_wr_en, fifo_din, fifo_rd_en, task_valid, task_word, drop
  );

  modport slave (
    output req_valid, req_op, req_data, fifo_full, fifo_empty, fifo_dout, task_ready,
    input  req_ready, fifo_wr_en, fifo_din, fifo_rd_en, task_valid, task_word, drop
  );

endinterface

// File: rtl/pifo_task_arbiter_rr.sv
// rr_arbiter: round-robin selector over TREE_NUM requesters.
//   clk, rst   : clock, synchronous active-high reset (pointer back to 0)
//   req        : request vector
//   enable     : when low no grant is issued and the pointer holds
//   grant      : one-hot grant, combinational in the request cycle
//   grant_vld  : any grant this cycle
//   grant_idx  : index of the granted requester
// The search starts at rr_ptr and wraps; after a grant to i the pointer
// moves to i+1 so the winner has lowest priority next time.
module rr_arbiter #(
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TREE_NUM-1:0]      req,
  input  logic                     enable,
  output logic [TREE_NUM-1:0]      grant,
  output logic                     grant_vld,
  output logic [TREE_NUM_BITS-1:0] grant_idx
);

  logic [TREE_NUM_BITS-1:0] rr_ptr;

  always_comb begin
    int                       idx;
    logic [TREE_NUM_BITS-1:0] idx_b;
    idx       = 0;
    idx_b     = '0;
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < TREE_NUM; k++) begin
      idx   = (int'(rr_ptr) + k) % TREE_NUM;
      idx_b = TREE_NUM_BITS'(idx);
      if (enable && !grant_vld && req[idx_b]) begin
        grant[idx_b] = 1'b1;
        grant_vld    = 1'b1;
        grant_idx    = idx_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == TREE_NUM_BITS'(TREE_NUM - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pifo_task_arbiter.sv
// pifo_task_arbiter: funnels TREE_NUM per-tree push/pop requesters into the
// shared task FIFO and dispatches FIFO entries to the PIFO core.
//   clk : system clock
//   rst : synchronous active-high reset (also resets the external FIFO)
//   bus : pifo_task_arbiter_if.master - requester, FIFO and core signals
// Front end: one round-robin grant per cycle, packed into {op, tree_id, data}
// (data zeroed for pops) and written in the grant cycle. Never writes while
// fifo_full is high.
// Back end: IDLE -> FETCH (read strobe) -> WAIT (capture read data) -> ISSUE
// (hold task until task_ready), i.e. at most one task every three cycles.
// Build option PIFO_TASK_ARB_GUARD_EN: per-tree occupancy counters; pops to an
// empty tree and pushes to a full tree are granted but not written, and drop
// pulses. Without it every grant is written and drop is tied low.
module pifo_task_arbiter
  import pifo_task_pkg::*;
#(
  parameter int PTW           = DEF_PTW,
  parameter int MTW           = DEF_MTW,
  parameter int TREE_NUM      = DEF_TREE_NUM,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int TW            = PTW + MTW + TREE_NUM_BITS + 1
`ifdef PIFO_TASK_ARB_GUARD_EN
  ,
  parameter int TREE_CAP      = DEF_TREE_CAP
`endif
) (
  input logic                 clk,
  input logic                 rst,
  pifo_task_arbiter_if.master bus
);

  localparam int DW = PTW + MTW;

  logic [TREE_NUM-1:0]      grant;
  logic                     grant_vld;
  logic [TREE_NUM_BITS-1:0] grant_idx;
  logic                     arb_en;
  logic                     grant_op;
  logic [DW-1:0]            grant_data;
  logic                     dropped;
  logic [TW-1:0]            din_p0;

  // ---- stage p0: arbitration and packing (combinational, grant cycle) ----
  assign arb_en = !rst && !bus.fifo_full;

  rr_arbiter #(
    .TREE_NUM      (TREE_NUM),
    .TREE_NUM_BITS (TREE_NUM_BITS)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .enable    (arb_en),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  always_comb begin
    grant_op   = OP_POP;
    grant_data = '0;
    for (int i = 0; i < TREE_NUM; i++) begin
      if (grant[i]) begin
        grant_op   = bus.req_op[i];
        grant_data = bus.req_data[i*DW +: DW];
      end
    end
  end

`ifdef PIFO_TASK_ARB_GUARD_EN
  localparam int CNT_W = $clog2(TREE_CAP + 1);

  logic [CNT_W-1:0] occ [TREE_NUM];
  logic [CNT_W-1:0] occ_sel;

  assign occ_sel = occ[grant_idx];
  assign dropped = grant_vld &&
                   (((grant_op == OP_POP)  && (occ_sel == '0)) ||
                    ((grant_op == OP_PUSH) && (occ_sel == CNT_W'(TREE_CAP))));

  // Counters follow what actually reaches the FIFO, so dropped requests
  // leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TREE_NUM; i++) occ[i] <= '0;
    end else if (grant_vld && !dropped) begin
      if (grant_op == OP_PUSH) occ[grant_idx] <= occ_sel + 1'b1;
      else                     occ[grant_idx] <= occ_sel - 1'b1;
    end
  end
`else
  assign dropped = 1'b0;
`endif

  assign din_p0 = grant_vld ?
                  {grant_op, grant_idx, ((grant_op == OP_PUSH) ? grant_data : {DW{1'b0}})} :
                  '0;

  assign bus.req_ready  = grant;
  assign bus.fifo_wr_en = grant_vld && !dropped;
  assign bus.fifo_din   = din_p0;
  assign bus.drop       = dropped;

  // ---- dispatch FSM ----
  disp_state_t   state_q, state_d;
  logic          rd_en;
  logic          task_vld;
  logic [TW-1:0] task_word_p1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // fifo_empty is used as seen this cycle; a write granted in the same
  // cycle only shows up as non-empty one cycle later.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    task_vld = 1'b0;
    unique case (state_q)
      S_IDLE:  if (!bus.fifo_empty) state_d = S_FETCH;
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:  state_d = S_ISSUE;
      S_ISSUE: begin
        task_vld = 1'b1;
        if (bus.task_ready) state_d = bus.fifo_empty ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage p1: FIFO read data captured in WAIT, held through ISSUE ----
  always_ff @(posedge clk) begin
    if (rst)                    task_word_p1 <= '0;
    else if (state_q == S_WAIT) task_word_p1 <= bus.fifo_dout;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.task_valid = task_vld;
  assign bus.task_word  = task_word_p1;

endmodule

// File: tb/tb_pifo_task_arbiter.sv
`timescale 1ns/1ps
module tb_pifo_task_arbiter;
  import pifo_task_pkg::*;

  localparam int N     = DEF_TREE_NUM;
  localparam int NB    = $clog2(N);
  localparam int DW    = DEF_PTW + DEF_MTW;
  localparam int TW    = DW + NB + 1;
  localparam int DEPTH = 8;
  localparam int CAP   = DEF_TREE_CAP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pifo_task_arbiter_if #(.PTW(DEF_PTW), .MTW(DEF_MTW), .TREE_NUM(N)) bus ();

  pifo_task_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  // Environment: task FIFO with one-cycle read latency, reset by rst.
  logic [TW-1:0] fq [$];
  int            fcnt = 0;
  logic [TW-1:0] fdout = '0;
  logic          force_full = 1'b0;

  assign bus.fifo_full  = force_full || (fcnt >= DEPTH);
  assign bus.fifo_empty = (fcnt == 0);
  assign bus.fifo_dout  = fdout;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fdout <= '0;
      fcnt  <= 0;
    end else begin
      if (bus.fifo_rd_en && fcnt > 0) fdout <= fq.pop_front();
      if (bus.fifo_wr_en && fcnt < DEPTH) fq.push_back(bus.fifo_din);
      fcnt <= fq.size();
    end
  end

  int rd_pulses = 0;
  always @(posedge clk) if (!rst && bus.fifo_rd_en) rd_pulses <= rd_pulses + 1;

  // Reference model state
  int            m_ptr = 0;
  int            m_occ [$] = '{0, 0, 0, 0};
  logic [TW-1:0] exp_q [$];
  int            accepted = 0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] v, input int i);
    logic [N*DW-1:0] t;
    t = v >> (i * DW);
    return t[DW-1:0];
  endfunction

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    d = '0;
    for (int i = 0; i < N * DW / 32; i++) d = (d << 32) | (N*DW)'($urandom);
    return d;
  endfunction

  // Called at the sample point of every cycle: predicts the arbiter outputs
  // from the request rules and checks dispatched tasks against the written order.
  task automatic model_check();
    logic [N-1:0]  eg;
    logic          ewr, edrop, op;
    logic [TW-1:0] edin;
    int            gi;
    eg = '0; ewr = 1'b0; edrop = 1'b0; edin = '0; gi = -1; op = 1'b0;
    if (rst) begin
      m_ptr = 0;
      foreach (m_occ[i]) m_occ[i] = 0;
      exp_q.delete();
    end else begin
      if (bus.task_valid && bus.task_ready) begin
        chk("task_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("task_word", bus.task_word, exp_q.pop_front());
        accepted++;
      end
      if (!bus.fifo_full)
        for (int k = 0; k < N; k++)
          if (gi < 0 && bitof(bus.req_valid, (m_ptr + k) % N)) gi = (m_ptr + k) % N;
      if (gi >= 0) begin
        op    = bitof(bus.req_op, gi);
        eg    = N'(1) << gi;
        m_ptr = (gi + 1) % N;
`ifdef PIFO_TASK_ARB_GUARD_EN
        if ((!op && m_occ[gi] == 0) || (op && m_occ[gi] == CAP)) edrop = 1'b1;
        else m_occ[gi] = m_occ[gi] + (op ? 1 : -1);
`endif
        ewr  = !edrop;
        edin = {op, NB'(gi), (op ? slice(bus.req_data, gi) : {DW{1'b0}})};
        if (ewr) exp_q.push_back(edin);
      end
    end
    chk("req_ready", bus.req_ready, eg);
    chk("fifo_wr_en", bus.fifo_wr_en, ewr);
    chk("drop", bus.drop, edrop);
    if (ewr || rst) chk("fifo_din", bus.fifo_din, edin);
  endtask

  task automatic apply(input logic r, input logic [N-1:0] v, input logic [N-1:0] op,
                       input logic [N*DW-1:0] d, input logic full, input logic rdy);
    @(negedge clk);
    rst            = r;
    bus.req_valid  = v;
    bus.req_op     = op;
    bus.req_data   = d;
    force_full     = full;
    bus.task_ready = rdy;
    #1;
    model_check();
  endtask

  task automatic reset_dut();
    apply(1'b1, '0, '0, '0, 1'b0, 1'b0);
    apply(1'b1, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N*DW-1:0] d;
    logic [TW-1:0]   held;
    task_t           tw;
    int              r0, a0;
    int              rdc [$];

    bus.req_valid = '0; bus.req_op = '0; bus.req_data = '0; bus.task_ready = 1'b0;
    d = {16'hA003, 16'h0303, 16'hA002, 16'h0202, 16'hA001, 16'h0101, 16'hA000, 16'h0000};

    // Reset state
    reset_dut();
    chk("rst_task_valid", bus.task_valid, 0);
    chk("rst_task_word", bus.task_word, 0);
    chk("rst_fifo_rd_en", bus.fifo_rd_en, 0);
    apply(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("idle_task_valid", bus.task_valid, 0);

    // Fairness: all trees pushing
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 4'hF, 4'hF, d, 1'b0, 1'b0);
      tw = bus.fifo_din;
      chk("fair_grant", bus.req_ready, 4'b0001 << (c % 4));
      chk("fair_tree_id", tw.tree_id, c % 4);
    end

    // Backpressure
    reset_dut();
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 4'b0011, 4'b0011, d, 1'b1, 1'b0);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_wr_en", bus.fifo_wr_en, 0);
    end
    apply(1'b0, 4'b0011, 4'b0011, d, 1'b0, 1'b0);
    chk("bp_release0", bus.req_ready, 4'b0001);
    apply(1'b0, 4'b0011, 4'b0011, d, 1'b0, 1'b0);
    chk("bp_release1", bus.req_ready, 4'b0010);

    // Dispatch handshake, single push to tree 1
    reset_dut();
    r0 = rd_pulses;
    apply(1'b0, 4'b0010, 4'b0010, d, 1'b0, 1'b0);
    apply(1'b0, '0, '0, d, 1'b0, 1'b0);
    chk("hs_nonempty", bus.fifo_empty, 0);
    chk("hs_valid_c1", bus.task_valid, 0);
    apply(1'b0, '0, '0, d, 1'b0, 1'b0);
    chk("hs_fetch_rd", bus.fifo_rd_en, 1);
    apply(1'b0, '0, '0, d, 1'b0, 1'b0);
    chk("hs_wait_rd", bus.fifo_rd_en, 0);
    chk("hs_valid_c3", bus.task_valid, 0);
    apply(1'b0, '0, '0, d, 1'b0, 1'b0);
    chk("hs_valid_c4", bus.task_valid, 1);
    chk("hs_word", bus.task_word, {1'b1, 2'd1, 16'hA001, 16'h0101});
    held = bus.task_word;
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, '0, '0, d, 1'b0, 1'b0);
      chk("hs_hold_valid", bus.task_valid, 1);
      chk("hs_hold_word", bus.task_word, held);
    end
    apply(1'b0, '0, '0, d, 1'b0, 1'b1);
    apply(1'b0, '0, '0, d, 1'b0, 1'b0);
    chk("hs_after_accept", bus.task_valid, 0);
    for (int c = 0; c < 3; c++) apply(1'b0, '0, '0, d, 1'b0, 1'b0);
    chk("hs_rd_pulses", rd_pulses - r0, 1);

    // Back-to-back dispatch of three queued pushes
    reset_dut();
    a0 = accepted;
    for (int c = 0; c < 15; c++) begin
      apply(1'b0, (c < 3) ? 4'b0111 : 4'b0000, 4'b0111, d, 1'b0, 1'b1);
      if (bus.fifo_rd_en) rdc.push_back(c);
    end
    chk("b2b_rd_count", rdc.size(), 3);
    if (rdc.size() == 3) begin
      chk("b2b_first_rd", rdc[0], 2);
      chk("b2b_gap0", rdc[1] - rdc[0], 3);
      chk("b2b_gap1", rdc[2] - rdc[1], 3);
    end
    chk("b2b_issued", accepted - a0, 3);
    chk("b2b_drained", exp_q.size(), 0);

    // Pop to an empty tree
    reset_dut();
    apply(1'b0, 4'b0100, 4'b0000, d, 1'b0, 1'b0);
    chk("pop_empty_ready", bus.req_ready, 4'b0100);
`ifdef PIFO_TASK_ARB_GUARD_EN
    chk("guard_pop_wr", bus.fifo_wr_en, 0);
    chk("guard_pop_drop", bus.drop, 1);
    apply(1'b0, 4'b0100, 4'b0100, d, 1'b0, 1'b0);
    chk("guard_push_wr", bus.fifo_wr_en, 1);
    apply(1'b0, 4'b0100, 4'b0000, d, 1'b0, 1'b0);
    chk("guard_pop2_wr", bus.fifo_wr_en, 1);
    chk("guard_pop2_drop", bus.drop, 0);
    apply(1'b0, 4'b0100, 4'b0000, d, 1'b0, 1'b0);
    chk("guard_back_to_zero", bus.drop, 1);
`else
    chk("noguard_pop_wr", bus.fifo_wr_en, 1);
    chk("noguard_drop", bus.drop, 0);
`endif

    // Reset while a task is in ISSUE
    reset_dut();
    apply(1'b0, 4'b0010, 4'b0010, d, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) apply(1'b0, '0, '0, d, 1'b0, 1'b0);
    chk("mid_issue_valid", bus.task_valid, 1);
    apply(1'b1, '0, '0, d, 1'b0, 1'b0);
    apply(1'b0, 4'hF, 4'hF, d, 1'b0, 1'b0);
    chk("mid_rst_valid", bus.task_valid, 0);
    chk("mid_rst_word", bus.task_word, 0);
    chk("mid_rst_ptr", bus.req_ready, 4'b0001);

    // Randomized traffic against the model, then drain
    reset_dut();
    for (int c = 0; c < 800; c++)
      apply(($urandom_range(0, 199) == 0), N'($urandom), N'($urandom), rand_data(),
            ($urandom_range(0, 9) == 0), 1'($urandom));
    for (int c = 0; c < 60; c++) apply(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("rand_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pifo_task_arbiter.md
# pifo_task_arbiter

- Round-robin arbiter and dispatcher between TREE_NUM per-tree push/pop requesters and the shared task FIFO that feeds the virtualized PIFO core.
- Front end: grants at most one request per cycle and packs it into a task word written to the FIFO.
- Back end: a dispatch FSM reads the FIFO, which has 1-cycle read latency, and presents each task to the PIFO core over a valid/ready handshake.
- Optional per-tree occupancy tracking drops pops to empty trees and pushes to full trees.

## Interface
- PTW, 16, payload width
- MTW, 16, metadata width
- TREE_NUM, 4, number of logical trees / requesters
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width
- TREE_CAP, 1024, per-tree element capacity (guard only)
- TW, PTW+MTW+TREE_NUM_BITS+1, task word width
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  TREE_NUM  per-tree request valid
- req_op  in  TREE_NUM  per-tree opcode: 1=push, 0=pop
- req_data  in  TREE_NUM*(PTW+MTW)  per-tree push data; slice i = bits [(i+1)*(PTW+MTW)-1 : i*(PTW+MTW)]
- req_ready  out  TREE_NUM  one-hot grant; request accepted this cycle
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  TW  task word {op, tree_id, data}; data is '0 for pop
- fifo_full  in  1  FIFO full
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  FIFO read strobe
- fifo_dout  in  TW  FIFO read data, valid the cycle after fifo_rd_en
- task_valid  out  1  task presented to core
- task_word  out  TW  task to core
- task_ready  in  1  core accepts task
- drop  out  1  pulse: accepted request discarded by guard

## Operation
- Arbitration:
  - Eligible iff req_valid[i] && !fifo_full.
  - Grant goes to the first valid index at or after rr_ptr, modulo TREE_NUM.
  - On a grant to i, rr_ptr <= (i+1) mod TREE_NUM. rr_ptr is unchanged with no grant.
  - req_ready is combinational in the same cycle.
  - fifo_wr_en = grant && !dropped; fifo_din = {req_op[i], i, push ? req_data slice i : '0}.
- The arbiter never writes while fifo_full is high, even if a read occurs the same cycle.
- Dispatch FSM, states IDLE, FETCH, WAIT, ISSUE:
  - IDLE → FETCH when !fifo_empty.
  - FETCH: fifo_rd_en=1 for one cycle → WAIT.
  - WAIT: capture fifo_dout into task_word → ISSUE.
  - ISSUE: task_valid=1, task_word held stable until task_ready.
  - On acceptance: → FETCH if !fifo_empty, else → IDLE.
- fifo_empty is sampled in the cycle of the decision; a same-cycle arbiter write is not visible until the next cycle.
- task_ready is ignored outside ISSUE.

## Timing
- Reset values: req_ready=0, fifo_wr_en=0, fifo_din=0, fifo_rd_en=0, task_valid=0, task_word=0, drop=0; rr_ptr=0; FSM=IDLE; occupancy counters=0.
- Requester to FIFO: 0 cycles; fifo_wr_en is asserted in the grant cycle.
- FIFO non-empty to task_valid: 3 cycles (IDLE→FETCH→WAIT→ISSUE).
- Sustained dispatch with task_ready tied high: 1 task per 3 cycles.
- Reset asserted mid-operation: the in-flight task in WAIT or ISSUE is abandoned and the FSM returns to IDLE. The FIFO is reset by the same rst.

## Configuration
- Macro: PIFO_TASK_ARB_GUARD_EN.
- Defined:
  - Per-tree counters of width $clog2(TREE_CAP+1) are updated at grant time: +1 on a written push, -1 on a written pop.
  - A pop granted while count==0, or a push granted while count==TREE_CAP, is accepted (req_ready=1) but not written; drop pulses for 1 cycle.
  - rr_ptr still advances.
- Undefined: no counters; every grant is written; drop is tied 0.

## Structure
- Package pifo_task_pkg holds:
  - op encoding constants OP_PUSH=1'b1, OP_POP=1'b0;
  - the dispatch state enum;
  - a packed task_t struct {op, tree_id, data} sized from PTW/MTW/TREE_NUM_BITS.
- Sub-module rr_arbiter: parameterized TREE_NUM round-robin with req, enable, grant and pointer update.
- The top level holds packing, the guard counters and the dispatch FSM.

## Test plan
- Fairness: TREE_NUM=4, all four req_valid held high with pushes → grants cycle 0,1,2,3,0; each fifo_din tree_id field matches the grant.
- Backpressure: fifo_full=1 with req_valid=4'b0011 → req_ready=0 and fifo_wr_en=0. Release → tree 0 is granted first (rr_ptr=0), tree 1 next cycle.
- Dispatch handshake: one push word in the FIFO, task_ready=0 for 5 cycles → task_valid rises 3 cycles after the FIFO goes non-empty and task_word stays stable. task_ready=1 → FSM goes to IDLE; exactly one fifo_rd_en pulse is observed.
- Back-to-back dispatch: 3 words queued, task_ready=1 → fifo_rd_en pulses every 3rd cycle and 3 tasks are issued in order.
- Guard (macro defined): pop to tree 2 after reset → req_ready[2]=1, fifo_wr_en=0, drop=1. Push then pop to tree 2 → both written, counter returns to 0.
- Reset mid-ISSUE: rst=1 for 1 cycle while task_valid=1 → next cycle task_valid=0, task_word=0, rr_ptr=0.
